// File: rtl/instr_mem_pkg.sv
// Shared types and default parameters for the boot-loaded instruction memory.
package instr_mem_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_ADDR_W = 10;
    localparam logic [DEF_DATA_W-1:0] DEF_HALT_WORD = 10'b0010000010;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/instr_mem_ram.sv
// Single-port DEPTH x DATA_W RAM: synchronous write, registered read, no reset.
module instr_mem_ram #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Write port and read register share one address; rdata holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory filled by a streaming loader, then served to the CPU fetch port.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              boot_done,
    output logic [ADDR_W:0]   prog_len,
    output logic              addr_err
);

    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH-1);

    state_t            state_r;
    logic [ADDR_W:0]   wr_ptr_r;
    logic [ADDR_W:0]   prog_len_r;
    logic [DATA_W-1:0] instr_hold_r;
    logic              use_ram_r;
    logic              instr_valid_r;
    logic              addr_err_r;

    logic              accept_s;
    logic              fetch_s;
    logic              in_range_s;
    logic              ram_re_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_q_s;

    // Handshake qualification, range compare and RAM port steering.
    always_comb begin
        accept_s   = (state_r == LOAD) && load_valid && !reload;
        fetch_s    = (state_r == RUN) && fetch_en && !stall && !reload;
        in_range_s = ({1'b0, fetch_addr} < prog_len_r);
        ram_re_s   = fetch_s && in_range_s;
        if (state_r == LOAD) begin
            ram_addr_s = wr_ptr_r[ADDR_W-1:0];
        end else begin
            ram_addr_s = fetch_addr;
        end
    end

    instr_mem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (load_data),
        .rdata (ram_q_s)
    );

    // LOAD/RUN sequencing, load pointer, and fetch output bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= LOAD;
            wr_ptr_r      <= '0;
            prog_len_r    <= '0;
            instr_hold_r  <= '0;
            use_ram_r     <= 1'b0;
            instr_valid_r <= 1'b0;
            addr_err_r    <= 1'b0;
        end else if (reload) begin
            state_r       <= LOAD;
            wr_ptr_r      <= '0;
            prog_len_r    <= '0;
            instr_valid_r <= 1'b0;
            addr_err_r    <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    instr_valid_r <= 1'b0;
                    if (accept_s) begin
                        wr_ptr_r <= wr_ptr_r + (ADDR_W+1)'(1);
                        if (load_last || (wr_ptr_r == LAST_PTR)) begin
                            prog_len_r <= wr_ptr_r + (ADDR_W+1)'(1);
                            state_r    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (fetch_en) begin
                            instr_valid_r <= 1'b1;
                            if (in_range_s) begin
                                use_ram_r <= 1'b1;
                            end else begin
                                // Out-of-range fetch returns the halt word from a local register.
                                use_ram_r    <= 1'b0;
                                instr_hold_r <= HALT_WORD;
                                addr_err_r   <= 1'b1;
                            end
                        end else begin
                            instr_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= LOAD;
                end
            endcase
        end
    end

    assign instr       = use_ram_r ? ram_q_s : instr_hold_r;
    assign instr_valid = instr_valid_r;
    assign load_ready  = (state_r == LOAD);
    assign boot_done   = (state_r == RUN);
    assign prog_len    = prog_len_r;
    assign addr_err    = addr_err_r;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed vector table, hand sequences, random run vs model.
module tb_instr_mem;

    localparam int DW    = 10;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] HALT = 10'h082;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          reload;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic          stall;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          boot_done;
    logic [AW:0]   prog_len;
    logic          addr_err;

    always #5 clk = ~clk;

    instr_mem #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .reload      (reload),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .boot_done   (boot_done),
        .prog_len    (prog_len),
        .addr_err    (addr_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_wp;
    int            m_plen;
    bit            m_run;
    bit            m_v;
    bit            m_err;
    logic [DW-1:0] m_instr;

    typedef struct {
        logic          rl;
        logic          lv;
        logic [DW-1:0] ld;
        logic          ll;
        logic          fe;
        logic [AW-1:0] fa;
        logic          st;
        logic [DW-1:0] e_instr;
        logic          e_v;
        logic          e_boot;
        int            e_plen;
        logic          e_err;
    } vec_t;

    vec_t vt [17];
    logic [DW-1:0] words [DEPTH];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        reload = 1'b0; fetch_en = 1'b0; fetch_addr = '0; stall = 1'b0;
    endtask

    task automatic model_reset();
        m_wp = 0; m_plen = 0; m_run = 0; m_v = 0; m_err = 0; m_instr = '0;
    endtask

    task automatic model_step();
        if (reload) begin
            m_run = 0; m_wp = 0; m_plen = 0; m_v = 0; m_err = 0;
        end else if (!m_run) begin
            m_v = 0;
            if (load_valid) begin
                m_mem[m_wp] = load_data;
                m_wp++;
                if (load_last || m_wp == DEPTH) begin
                    m_plen = m_wp;
                    m_run  = 1;
                end
            end
        end else if (!stall) begin
            if (fetch_en) begin
                m_v = 1;
                if (int'(fetch_addr) < m_plen) m_instr = m_mem[fetch_addr];
                else begin
                    m_instr = HALT;
                    m_err   = 1;
                end
            end else begin
                m_v = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr"}, int'(instr), int'(m_instr));
        chk({tag, ".instr_valid"}, int'(instr_valid), int'(m_v));
        chk({tag, ".boot_done"}, int'(boot_done), int'(m_run));
        chk({tag, ".load_ready"}, int'(load_ready), int'(!m_run));
        chk({tag, ".prog_len"}, int'(prog_len), m_plen);
        chk({tag, ".addr_err"}, int'(addr_err), int'(m_err));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        //            rl    lv    ld      ll    fe    fa    st    instr   v     boot  plen err
        vt[0]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 5'd0, 1'b0, 10'h000, 1'b0, 1'b0, 0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 10'h370, 1'b0, 1'b0, 5'd0, 1'b0, 10'h000, 1'b0, 1'b0, 0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 10'h36D, 1'b1, 1'b0, 5'd0, 1'b0, 10'h000, 1'b0, 1'b1, 3, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd1, 1'b0, 10'h370, 1'b1, 1'b1, 3, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 5'd0, 1'b0, 10'h370, 1'b0, 1'b1, 3, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd5, 1'b0, 10'h082, 1'b1, 1'b1, 3, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd0, 1'b0, 10'h000, 1'b1, 1'b1, 3, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd1, 1'b0, 10'h370, 1'b1, 1'b1, 3, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd0, 1'b1, 10'h370, 1'b1, 1'b1, 3, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd1, 1'b1, 10'h370, 1'b1, 1'b1, 3, 1'b1};
        vt[10] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd2, 1'b1, 10'h370, 1'b1, 1'b1, 3, 1'b1};
        vt[11] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 5'd0, 1'b0, 10'h370, 1'b0, 1'b1, 3, 1'b1};
        vt[12] = '{1'b1, 1'b1, 10'h111, 1'b0, 1'b1, 5'd1, 1'b0, 10'h370, 1'b0, 1'b0, 0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 10'h2AA, 1'b1, 1'b1, 5'd0, 1'b0, 10'h370, 1'b0, 1'b1, 1, 1'b0};
        vt[14] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 5'd0, 1'b0, 10'h2AA, 1'b1, 1'b1, 1, 1'b0};
        vt[15] = '{1'b0, 1'b1, 10'h155, 1'b0, 1'b1, 5'd1, 1'b0, 10'h082, 1'b1, 1'b1, 1, 1'b1};
        vt[16] = '{1'b0, 1'b1, 10'h155, 1'b1, 1'b1, 5'd0, 1'b0, 10'h2AA, 1'b1, 1'b1, 1, 1'b1};

        do_reset();
        chk("rst.instr", int'(instr), 0);
        chk("rst.instr_valid", int'(instr_valid), 0);
        chk("rst.boot_done", int'(boot_done), 0);
        chk("rst.load_ready", int'(load_ready), 1);
        chk("rst.prog_len", int'(prog_len), 0);
        chk("rst.addr_err", int'(addr_err), 0);

        for (int i = 0; i < 17; i++) begin
            reload = vt[i].rl; load_valid = vt[i].lv; load_data = vt[i].ld;
            load_last = vt[i].ll; fetch_en = vt[i].fe; fetch_addr = vt[i].fa;
            stall = vt[i].st;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.instr", i), int'(instr), int'(vt[i].e_instr));
            chk($sformatf("vec%0d.instr_valid", i), int'(instr_valid), int'(vt[i].e_v));
            chk($sformatf("vec%0d.boot_done", i), int'(boot_done), int'(vt[i].e_boot));
            chk($sformatf("vec%0d.load_ready", i), int'(load_ready), int'(!vt[i].e_boot));
            chk($sformatf("vec%0d.prog_len", i), int'(prog_len), vt[i].e_plen);
            chk($sformatf("vec%0d.addr_err", i), int'(addr_err), int'(vt[i].e_err));
        end

        // Full 32-word image without load_last
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = DW'($urandom);
            load_valid = 1'b1; load_data = words[i]; load_last = 1'b0;
            cycle("full_load");
        end
        idle();
        chk("full.prog_len", int'(prog_len), 32);
        fetch_en = 1'b1; fetch_addr = 5'd31;
        cycle("full_fetch");
        chk("full.fetch31", int'(instr), int'(words[31]));

        // Reset in the middle of a load discards progress
        idle();
        reload = 1'b1;
        cycle("mid_reload");
        idle();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = DW'(10'h101 + i);
            cycle("mid_load");
        end
        idle();
        rst = 1'b1;
        #2;
        model_reset();
        chk("async.instr", int'(instr), 0);
        chk("async.load_ready", int'(load_ready), 1);
        chk("async.boot_done", int'(boot_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_valid = 1'b1; load_data = 10'h3FF; load_last = 1'b1;
        cycle("restart_load");
        idle();
        fetch_en = 1'b1; fetch_addr = 5'd0;
        cycle("restart_fetch");
        chk("restart.addr0", int'(instr), 10'h3FF);
        chk("restart.prog_len", int'(prog_len), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reload     = ($urandom_range(0, 24) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = DW'($urandom);
            load_last  = ($urandom_range(0, 7) == 0);
            fetch_en   = ($urandom_range(0, 3) != 0);
            fetch_addr = AW'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter DATA_W, default 10: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 10: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter HALT_WORD, default 10'b0010000010: word returned for out-of-range fetches.
REQ-004 Ports: clk  in  1  sole clock, rising edge.
REQ-005 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: load_valid  in  1  loader word present.
REQ-007 Ports: load_data  in  DATA_W  loader word.
REQ-008 Ports: load_last  in  1  marks final loader word.
REQ-009 Ports: load_ready  out  1  block accepts loader word.
REQ-010 Ports: reload  in  1  return to LOAD and restart the program image.
REQ-011 Ports: fetch_en  in  1  CPU fetch request.
REQ-012 Ports: fetch_addr  in  ADDR_W  fetch address.
REQ-013 Ports: stall  in  1  CPU stall; freeze fetch output.
REQ-014 Ports: instr  out  DATA_W  fetched word, registered.
REQ-015 Ports: instr_valid  out  1  instr holds a completed fetch.
REQ-016 Ports: boot_done  out  1  program image loaded; block in RUN.
REQ-017 Ports: prog_len  out  ADDR_W+1  number of words loaded (0..DEPTH).
REQ-018 Ports: addr_err  out  1  sticky flag: an out-of-range fetch occurred.

Function
REQ-019 The FSM SHALL have two states: LOAD and RUN; boot_done = (state==RUN).
REQ-020 load_ready SHALL be 1 exactly when state==LOAD; a word is accepted on a cycle with load_valid && load_ready.
REQ-021 Each accepted word SHALL be written to mem[wr_ptr], and wr_ptr SHALL increment by 1; loading starts at address 0.
REQ-022 Accepting a word with load_last=1, or accepting the word at wr_ptr==DEPTH-1, SHALL set prog_len=wr_ptr+1 and move to RUN on the next cycle; wr_ptr never wraps.
REQ-023 load_valid in RUN SHALL be ignored, and memory SHALL NOT be written in RUN.
REQ-024 In RUN, with fetch_en=1 and stall=0, the block SHALL update instr and set instr_valid=1 one cycle later (latency 1).
REQ-025 The fetched value SHALL be mem[fetch_addr] if fetch_addr < prog_len; otherwise it SHALL be HALT_WORD, and addr_err SHALL set to 1.
REQ-026 In RUN, fetch_en=0 with stall=0 SHALL clear instr_valid; instr holds its value.
REQ-027 With stall=1, instr and instr_valid SHALL hold; fetch_en and fetch_addr are ignored.
REQ-028 In LOAD, fetches SHALL be ignored and instr_valid SHALL be 0.
REQ-029 reload=1 in any state SHALL take effect on the next cycle and override a simultaneous fetch, stall or load. Its effects are: state LOAD, wr_ptr 0, prog_len 0, instr_valid 0, addr_err 0.
REQ-030 A word presented in the same cycle as reload SHALL NOT be written.
REQ-031 addr_err SHALL clear only on rst or reload.

Reset
REQ-032 rst SHALL asynchronously force: state LOAD, wr_ptr 0, prog_len 0, instr 0, instr_valid 0, addr_err 0.
REQ-033 After rst, load_ready SHALL be 1 and boot_done SHALL be 0.
REQ-034 Memory contents SHALL NOT be reset, which preserves RAM inference.
REQ-035 rst asserted mid-load SHALL discard progress; the next load restarts at address 0.

Structure
REQ-036 Package instr_mem_pkg SHALL hold the state enum (LOAD, RUN), the default HALT_WORD, and the default DATA_W/ADDR_W.
REQ-037 Storage SHALL be one sub-module, instr_mem_ram: single-port RAM with synchronous write and synchronous read of DEPTH x DATA_W words.
REQ-038 instr_mem_ram SHALL have no reset.
REQ-039 instr_mem SHALL contain the FSM, wr_ptr, prog_len, the range compare and the output registers.

Verification (DATA_W=10, ADDR_W=5)
REQ-040 Scenario: after rst, load 0x000, 0x370, 0x36D with load_last on the third -> boot_done=1 the next cycle, prog_len=3, load_ready=0.
REQ-041 Scenario: fetch_en=1, fetch_addr=1 -> next cycle instr=0x370, instr_valid=1; then fetch_en=0 -> instr_valid=0 and instr stays 0x370.
REQ-042 Scenario: fetch_addr=5 with prog_len=3 -> instr=0x082, addr_err=1; addr_err stays 1 after later in-range fetches.
REQ-043 Scenario: stall=1 for 3 cycles while fetch_addr steps 0, 1, 2 -> instr and instr_valid unchanged throughout.
REQ-044 Scenario: load 32 words without load_last -> RUN after the 32nd, prog_len=32; fetch_addr=31 returns the 32nd word.
REQ-045 Scenario: reload together with fetch_en in RUN -> next cycle instr_valid=0, boot_done=0, load_ready=1, addr_err=0; rst mid-load -> the next word lands at address 0.
